// File: rtl/tt_axis_pkg.sv
// Shared types and helpers for the time-tag AXI-Stream arbitration path.
package tt_axis_pkg;

    localparam int unsigned MAX_PORTS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First requesting port scanning last+1, last+2, ... modulo num_ports.
    function automatic int unsigned rr_next(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned last,
                                            input int unsigned num_ports);
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            if (k <= num_ports) begin
                idx = (last + k) % num_ports;
                if (!found && req[idx[3:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_interface.sv
// AXI-Stream bundle shared by the time-tag producers and consumers.
interface axis_interface #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 32,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered in_ready and fully registered outputs.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 32,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic [USER_WIDTH-1:0] out_user,
    output logic                  out_last
);
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] out_pay_q, out_pay_d;
    logic [PW-1:0] skid_pay_q, skid_pay_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          push, pop;

    assign in_pay   = {in_data, in_keep, in_user, in_last};
    assign in_ready = ~skid_valid_q;

    always_comb begin
        push         = in_valid & ~skid_valid_q;
        pop          = out_valid_q & out_ready;
        out_valid_d  = out_valid_q;
        out_pay_d    = out_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        if (!out_valid_q || pop) begin
            // Output slot frees up: refill from the skid entry first to keep order.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) out_pay_d = in_pay;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_pay_q    <= '0;
            skid_pay_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_pay_q    <= out_pay_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_data, out_keep, out_user, out_last} = out_pay_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS time-tag streams onto one output.
module axis_packet_arbiter
    import tt_axis_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 32,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int TAG_SOURCE = 1,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    axis_interface.slave     s_axis [NUM_PORTS],
    axis_interface.master    m_axis,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [31:0]      pkt_count
);
    arb_state_t state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [31:0]      pkt_count_q, pkt_count_d;

    logic [NUM_PORTS-1:0]  req_valid, req_last, tready_vec;
    logic [DATA_WIDTH-1:0] req_data [NUM_PORTS];
    logic [KEEP_WIDTH-1:0] req_keep [NUM_PORTS];
    logic [USER_WIDTH-1:0] req_user [NUM_PORTS];
    logic [MAX_PORTS-1:0]  req_ext;

    logic                  in_valid, in_ready, in_last;
    logic [DATA_WIDTH-1:0] in_data;
    logic [KEEP_WIDTH-1:0] in_keep;
    logic [USER_WIDTH-1:0] in_user;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign req_valid[i]     = s_axis[i].tvalid;
        assign req_last[i]      = s_axis[i].tlast;
        assign req_data[i]      = s_axis[i].tdata;
        assign req_keep[i]      = s_axis[i].tkeep;
        assign req_user[i]      = s_axis[i].tuser;
        assign s_axis[i].tready = tready_vec[i];
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        tready_vec    = '0;
        in_valid      = 1'b0;
        req_ext       = '0;
        req_ext[NUM_PORTS-1:0] = req_valid;

        in_data = req_data[grant_idx_q];
        in_keep = req_keep[grant_idx_q];
        in_last = req_last[grant_idx_q];
        in_user = req_user[grant_idx_q];
        if (TAG_SOURCE != 0) in_user[IDX_W-1:0] = grant_idx_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_idx_d   = IDX_W'(rr_next(req_ext, 32'(last_grant_q), NUM_PORTS));
                    last_grant_d  = grant_idx_d;
                    grant_valid_d = 1'b1;
                    state_d       = LOCKED;
                end
            end
            LOCKED: begin
                tready_vec[grant_idx_q] = in_ready;
                in_valid = req_valid[grant_idx_q];
                if (in_valid && in_ready && in_last) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pkt_count_d = pkt_count_q;
        if (m_axis.tvalid && m_axis.tready && m_axis.tlast) pkt_count_d = pkt_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            grant_valid_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_user   (in_user),
        .in_last   (in_last),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready),
        .out_data  (m_axis.tdata),
        .out_keep  (m_axis.tkeep),
        .out_user  (m_axis.tuser),
        .out_last  (m_axis.tlast)
    );

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter that shares one `axis_interface` time-tag stream among `NUM_PORTS` upstream producers (channel-group tag sources, test-pattern generator, replay engine). A grant is held from the first beat of a packet to the beat carrying `tlast`, so packets are never interleaved. Output is registered through a 2-entry skid buffer for full throughput and timing closure ahead of the downstream FIFO or Ethernet packer.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters, legal range 2..16.
- `DATA_WIDTH`, 64: `tdata` width; must match all attached interfaces.
- `USER_WIDTH`, 32: `tuser` width; must be at least `IDX_W`.
- `KEEP_WIDTH`, (DATA_WIDTH+7)/8: `tkeep` width.
- `TAG_SOURCE`, 1: when 1, `m_axis.tuser[IDX_W-1:0]` is overwritten with the granted index. When 0, `tuser` passes through unchanged.

Ports:
- `clk`  input  1  sole clock; all logic is in this domain.
- `rst_n`  input  1  asynchronous, active-low reset. Deassertion is synchronised to `clk` by the caller.
- `s_axis`  slave modport  `axis_interface` array [NUM_PORTS]  requester streams.
- `m_axis`  master modport  `axis_interface`  arbitrated output.
- `grant_valid`  output  1  a packet is currently locked.
- `grant_idx`  output  IDX_W  index of the locked or last-granted port; IDX_W = max(1, $clog2(NUM_PORTS)).
- `pkt_count`  output  32  packets completed on `m_axis`; wraps modulo 2^32.

## Operation
- FSM with two states, IDLE and LOCKED.
- **IDLE**
  - All `s_axis[i].tready` = 0.
  - If any `s_axis[i].tvalid` = 1, select the first valid port scanning `last_grant+1, last_grant+2, …` modulo `NUM_PORTS`.
  - Register the selection in `grant_idx` and `last_grant`, set `grant_valid`, and move to LOCKED.
  - With no request, stay in IDLE.
- **LOCKED**
  - `s_axis[grant_idx].tready` = skid-buffer `in_ready`; every other port's `tready` = 0.
  - A beat transfers when `tvalid & tready`. `tdata`, `tkeep`, `tlast` and `tuser` (with the tag applied) enter the skid buffer.
  - On a transfer with `tlast` = 1: go to IDLE and clear `grant_valid`. `grant_idx` holds its value.
- Arbitration is evaluated only in IDLE. Requests arriving in LOCKED wait, so a packet is never preempted.
- A requester dropping `tvalid` mid-packet is legal. The grant is held until its `tlast` beat; there is no timeout.
- `pkt_count` increments when `m_axis.tvalid & m_axis.tready & m_axis.tlast`.
- Fairness: a port with continuous demand waits at most NUM_PORTS−1 packets.

## Timing
- Reset values:
  - `m_axis.tvalid` = 0, all `s_axis[i].tready` = 0.
  - `grant_valid` = 0, `grant_idx` = 0, `last_grant` = NUM_PORTS−1, so port 0 wins first.
  - `pkt_count` = 0, skid buffer empty, FSM in IDLE.
- Reset asserted mid-packet takes effect immediately: the packet is truncated and buffered beats are discarded. Upstream must also be reset.
- Arbitration latency: a request seen in cycle t is locked at the edge ending t. `tready` is high in t+1.
- Data latency: a beat accepted in cycle t is on `m_axis` in t+1, so the first beat after IDLE appears at t+2.
- One dead cycle occurs between packets (the LOCKED→IDLE→LOCKED pass), so peak throughput is L/(L+1) for L-beat packets.
- Skid buffer:
  - `in_ready` is registered and equals "second entry empty".
  - All `m_axis` outputs come from flops.
  - Full rate is sustained while `m_axis.tready` = 1.
  - When `m_axis.tready` falls, at most one extra beat is absorbed.
- Back-pressure: `m_axis.tvalid` is never retracted before handshake, and `m_axis` data is stable while `tvalid & !tready`.

## Structure
- The shared package `tt_axis_pkg` holds:
  - the FSM state enum `arb_state_t` {IDLE, LOCKED};
  - the function `rr_next(req, last)` returning the round-robin winner index.
- Sub-module `axis_skid_buffer` (2-entry, DATA/KEEP/USER widths as parameters) is reusable elsewhere in the datapath.
- The arbiter top holds the FSM, request scan, input mux and counter.

## Test plan
- Single port: port 2 sends a 3-beat packet (tdata 0xA,0xB,0xC) with `m_axis.tready`=1 → output shows beats at t+2..t+4, `tuser[1:0]`=2, `pkt_count`=1.
- All four ports continuously request 2-beat packets → grant order 0,1,2,3,0,…; each packet is 3 cycles including the dead cycle; no interleaving.
- Port 1 is mid-packet and port 0 requests → port 0 is not granted until port 1's `tlast` handshake, then granted next, because it is first in the scan from `last_grant`+1 = 2 that is valid (…3,0).
- `m_axis.tready` is toggled randomly at 50% with a 16-beat packet → all 16 beats arrive in order, none duplicated, and output stays stable while stalled.
- `rst_n` pulsed low during beat 5 of 10 → `m_axis.tvalid`=0 and `grant_valid`=0 in the same cycle; after release, port 0 wins first.
- Force `pkt_count` to 0xFFFF_FFFF, then complete one packet → `pkt_count` = 0.
